// File: rtl/htpa_pkg.sv
// rtl/htpa_pkg.sv - shared HTPA frame geometry constants and window FSM state type
package htpa_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 64;
    localparam int X_W    = 7;
    localparam int Y_W    = 6;
    localparam int ADDR_W = 13;
    localparam int CNT_W  = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } win_state_t;

endpackage

// File: rtl/htpa_win_stats.sv
// rtl/htpa_win_stats.sv - per-window pixel count/sum/min/max accumulators
module htpa_win_stats
    import htpa_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int SUM_W = PIX_W + CNT_W
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               upd,
    input  logic [PIX_W-1:0]   data,
    output logic [CNT_W-1:0]   count,
    output logic [SUM_W-1:0]   sum,
    output logic [PIX_W-1:0]   min_val,
    output logic [PIX_W-1:0]   max_val
);

    // Clear seeds min with all-ones so the first pixel always wins; clear beats update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            sum     <= '0;
            min_val <= '0;
            max_val <= '0;
        end else if (clr) begin
            count   <= '0;
            sum     <= '0;
            min_val <= '1;
            max_val <= '0;
        end else if (upd) begin
            count <= count + CNT_W'(1);
            sum   <= sum + SUM_W'(data);
            if (data < min_val) begin
                min_val <= data;
            end
            if (data > max_val) begin
                max_val <= data;
            end
        end
    end

endmodule

// File: rtl/htpa_ram_window_reader.sv
// rtl/htpa_ram_window_reader.sv - window coordinate to frame-RAM reader with pixel return and stats
module htpa_ram_window_reader
    import htpa_pkg::*;
#(
    parameter int COLS   = htpa_pkg::COLS,
    parameter int ROWS   = htpa_pkg::ROWS,
    parameter int PIX_W  = 16,
    parameter int RD_LAT = 2
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [X_W-1:0]          x,
    input  logic [Y_W-1:0]          y,
    input  logic                    set,
    output logic                    ram_rd_en,
    output logic [ADDR_W-1:0]       ram_addr,
    input  logic [PIX_W-1:0]        ram_rdata,
    output logic                    pix_valid,
    output logic [X_W-1:0]          pix_x,
    output logic [Y_W-1:0]          pix_y,
    output logic [PIX_W-1:0]        pix_data,
    output logic                    win_done,
    output logic [CNT_W-1:0]        win_count,
    output logic [PIX_W+CNT_W-1:0]  win_sum,
    output logic [PIX_W-1:0]        win_min,
    output logic [PIX_W-1:0]        win_max,
    output logic                    oob_err
);

    localparam int LAST = RD_LAT - 1;

    win_state_t state;
    win_state_t state_nxt;

    logic              accept;
    logic              clr;
    logic              drop;
    logic              in_range;
    logic              pipe_empty;
    logic              ret_hit;
    logic [ADDR_W-1:0] addr_lin;

    // One slot per accepted coordinate; in-range flag travels with it so
    // out-of-range slots keep ordering but never produce a pixel.
    logic [RD_LAT-1:0] dl_v;
    logic [RD_LAT-1:0] dl_in;
    logic [X_W-1:0]    dl_x [RD_LAT];
    logic [Y_W-1:0]    dl_y [RD_LAT];

    assign in_range   = (32'(x) < COLS) && (32'(y) < ROWS);
    assign pipe_empty = ~|dl_v;
    assign ret_hit    = dl_v[LAST] & dl_in[LAST];
    assign win_done   = (state == ST_DONE);

    // Linear address: the 80-column frame uses shift-and-add instead of a multiplier.
    generate
        if (COLS == 80) begin : g_addr_shift
            assign addr_lin = (ADDR_W'(y) << 6) + (ADDR_W'(y) << 4) + ADDR_W'(x);
        end else begin : g_addr_mul
            assign addr_lin = ADDR_W'(32'(y) * COLS + 32'(x));
        end
    endgenerate

    // Window state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus accept/clear/drop strobes; only IDLE may open a window.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        clr       = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (set) begin
                    accept    = 1'b1;
                    clr       = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (set) begin
                    accept = 1'b1;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drop = set;
                if (pipe_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                drop      = set;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address stage: read strobe only for in-range coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
        end else begin
            ram_rd_en <= accept & in_range;
            if (accept) begin
                ram_addr <= addr_lin;
            end
        end
    end

    // Valid/x/y delay line aligned so the last stage meets ram_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_v  <= '0;
            dl_in <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dl_x[i] <= '0;
                dl_y[i] <= '0;
            end
        end else begin
            dl_v[0]  <= accept;
            dl_in[0] <= accept & in_range;
            dl_x[0]  <= x;
            dl_y[0]  <= y;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_v[i]  <= dl_v[i-1];
                dl_in[i] <= dl_in[i-1];
                dl_x[i]  <= dl_x[i-1];
                dl_y[i]  <= dl_y[i-1];
            end
        end
    end

    // Pixel return register; coordinates and data hold between valid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
        end else begin
            pix_valid <= ret_hit;
            if (ret_hit) begin
                pix_x    <= dl_x[LAST];
                pix_y    <= dl_y[LAST];
                pix_data <= ram_rdata;
            end
        end
    end

    // Sticky error: cleared when a window opens, set by out-of-range or dropped coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err <= 1'b0;
        end else if (clr) begin
            oob_err <= ~in_range;
        end else if ((accept & ~in_range) | drop) begin
            oob_err <= 1'b1;
        end
    end

    htpa_win_stats #(
        .PIX_W (PIX_W),
        .SUM_W (PIX_W + CNT_W)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .upd     (ret_hit),
        .data    (ram_rdata),
        .count   (win_count),
        .sum     (win_sum),
        .min_val (win_min),
        .max_val (win_max)
    );

endmodule

// File: tb/tb_htpa_ram_window_reader.sv
// tb/tb_htpa_ram_window_reader.sv - directed scoreboard bench for htpa_ram_window_reader
module tb_htpa_ram_window_reader #(
    parameter int RD_LAT = 2
);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        set;
    logic        ram_rd_en;
    logic [12:0] ram_addr;
    logic [15:0] ram_rdata;
    logic        pix_valid;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
    logic [15:0] pix_data;
    logic        win_done;
    logic [12:0] win_count;
    logic [28:0] win_sum;
    logic [15:0] win_min;
    logic [15:0] win_max;
    logic        oob_err;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [28:0] sb [$];

    int          data_mode  = 0;
    logic [15:0] data_const = 16'h0000;

    int          exp_count;
    longint      exp_sum;
    logic [15:0] exp_min;
    logic [15:0] exp_max;
    logic        exp_oob;

    logic [12:0] ahist [1:4];
    logic [12:0] rd_sel;

    always #5 clk = ~clk;

    htpa_ram_window_reader #(
        .COLS   (80),
        .ROWS   (64),
        .PIX_W  (16),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .set       (set),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data),
        .win_done  (win_done),
        .win_count (win_count),
        .win_sum   (win_sum),
        .win_min   (win_min),
        .win_max   (win_max),
        .oob_err   (oob_err)
    );

    function automatic logic [15:0] data_of(input int mode, input logic [15:0] cval, input logic [12:0] a);
        logic [15:0] w;
        w = {3'b000, a};
        case (mode)
            0:       return cval;
            1:       return w;
            default: return (w * 16'd40503) ^ 16'h5a5a;
        endcase
    endfunction

    // Frame RAM: data for the address registered at edge N is presented for sampling at edge N+RD_LAT.
    always @(posedge clk) begin
        ahist[1] <= ram_addr;
        ahist[2] <= ahist[1];
        ahist[3] <= ahist[2];
        ahist[4] <= ahist[3];
    end

    always_comb begin
        case (RD_LAT)
            1:       rd_sel = ram_addr;
            2:       rd_sel = ahist[1];
            3:       rd_sel = ahist[2];
            default: rd_sel = ahist[3];
        endcase
        ram_rdata = data_of(data_mode, data_const, rd_sel);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returned pixels must match the scoreboard in order.
    always @(negedge clk) begin
        if (win_done) begin
            done_cnt++;
        end
        if (pix_valid) begin
            if (sb.size() == 0) begin
                chk("pix_unexpected", pix_valid, 0);
            end else begin
                chk("pix", {pix_x, pix_y, pix_data}, sb.pop_front());
            end
        end
    end

    task automatic window_begin();
        exp_count = 0;
        exp_sum   = 0;
        exp_min   = 16'hFFFF;
        exp_max   = 16'h0000;
        exp_oob   = 1'b0;
    endtask

    task automatic send_coord(input int cx, input int cy);
        logic        inr;
        logic [12:0] a;
        logic [15:0] d;
        inr = (cx < 80) && (cy < 64);
        a   = 13'(cy * 80 + cx);
        x   = 7'(cx);
        y   = 6'(cy);
        set = 1'b1;
        if (inr) begin
            d = data_of(data_mode, data_const, a);
            sb.push_back({7'(cx), 6'(cy), d});
            exp_count++;
            exp_sum += longint'(d);
            if (d < exp_min) exp_min = d;
            if (d > exp_max) exp_max = d;
        end else begin
            exp_oob = 1'b1;
        end
        @(negedge clk);
        chk("rd_en", ram_rd_en, inr);
        if (inr) begin
            chk("addr", ram_addr, a);
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_count"}, win_count, exp_count);
        chk({tag, "_sum"}, win_sum, exp_sum);
        chk({tag, "_min"}, win_min, exp_min);
        chk({tag, "_max"}, win_max, exp_max);
        chk({tag, "_oob"}, oob_err, exp_oob);
    endtask

    task automatic wait_done(input string tag);
        int i;
        set = 1'b0;
        i   = 0;
        while (!win_done && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done_seen"}, win_done, 1);
        check_stats(tag);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, win_done, 0);
        chk({tag, "_count_hold"}, win_count, exp_count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre_done;
        rst_n = 1'b0;
        set   = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_pix", {pix_valid, pix_x, pix_y, pix_data}, 0);
        chk("rst_done", win_done, 0);
        chk("rst_stats", {win_count, win_sum, win_min, win_max, oob_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pixel with exact latency check.
        data_mode  = 0;
        data_const = 16'h1234;
        window_begin();
        send_coord(5, 3);
        chk("single_addr245", ram_addr, 245);
        set = 1'b0;
        for (int k = 0; k <= RD_LAT + 2; k++) begin
            chk("single_pv", pix_valid, (k == RD_LAT));
            chk("single_done", win_done, (k == RD_LAT + 1));
            if (k == RD_LAT + 1) begin
                check_stats("single");
            end
            @(negedge clk);
        end

        // Full row, data = address.
        data_mode = 1;
        window_begin();
        for (int i = 0; i < 80; i++) send_coord(i, 0);
        wait_done("row");
        chk("row_sum3160", win_sum, 3160);

        // Out-of-range slots mid-window and trailing.
        data_mode = 2;
        window_begin();
        send_coord(0, 2);
        send_coord(1, 2);
        send_coord(85, 2);
        send_coord(2, 2);
        send_coord(3, 2);
        send_coord(100, 5);
        wait_done("oob");

        // Scattered coordinates for min/max coverage.
        window_begin();
        for (int i = 0; i < 30; i++) send_coord($urandom_range(79, 0), $urandom_range(63, 0));
        wait_done("rand");

        // set re-asserted during DRAIN is dropped.
        data_mode = 1;
        window_begin();
        send_coord(10, 10);
        send_coord(11, 10);
        send_coord(12, 10);
        set = 1'b0;
        @(negedge clk);
        set = 1'b1;
        x   = 7'd20;
        y   = 6'd10;
        @(negedge clk);
        set = 1'b0;
        chk("drain_drop_rd_en", ram_rd_en, 0);
        exp_oob = 1'b1;
        wait_done("drain");

        // Full frame, all 0xFFFF.
        data_mode  = 0;
        data_const = 16'hFFFF;
        window_begin();
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 80; c++) send_coord(c, r);
        end
        wait_done("frame");
        chk("frame_sum_nowrap", win_sum, 64'd335539200);

        // Reset mid-window after 10 coordinates.
        data_mode = 2;
        window_begin();
        for (int i = 0; i < 10; i++) send_coord(i + 20, 40);
        pre_done = done_cnt;
        #2;
        rst_n = 1'b0;
        set   = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_rd_en", ram_rd_en, 0);
        chk("mid_rst_pix", {pix_valid, pix_x, pix_y, pix_data}, 0);
        chk("mid_rst_stats", {win_count, win_sum, win_min, win_max, oob_err, win_done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (RD_LAT + 4) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, pre_done);
        chk("mid_rst_no_pix", pix_valid, 0);
        window_begin();
        send_coord(7, 7);
        send_coord(8, 7);
        wait_done("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/htpa_ram_window_reader.md
# htpa_ram_window_reader

Consumer end of the HTPA frame-RAM window scan. Samples the coordinate stream (x, y, set) produced by the window scanner and converts each coordinate to a linear frame-RAM read address. It returns the pixel data with its coordinates, accounting for a fixed RAM read latency. It also accumulates per-window statistics (count, sum, min, max) and issues a one-cycle done pulse when the last pixel of a window has been returned.

## Interface
Parameters:
- COLS, 80, frame width in pixels
- ROWS, 64, frame height in pixels
- PIX_W, 16, pixel width, unsigned
- RD_LAT, 2, frame-RAM read latency in cycles, legal range 1..4

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- x  in  7  scan column
- y  in  6  scan row
- set  in  1  coordinate valid this cycle
- ram_rd_en  out  1  frame-RAM read strobe
- ram_addr  out  13  linear read address, y*COLS + x
- ram_rdata  in  PIX_W  read data, valid RD_LAT cycles after ram_rd_en
- pix_valid  out  1  pix_* outputs valid
- pix_x  out  7  column of returned pixel
- pix_y  out  6  row of returned pixel
- pix_data  out  PIX_W  returned pixel value
- win_done  out  1  one-cycle pulse, window complete, stats stable
- win_count  out  13  in-range pixels in window
- win_sum  out  PIX_W+13  sum of in-range pixels
- win_min  out  PIX_W  minimum in-range pixel
- win_max  out  PIX_W  maximum in-range pixel
- oob_err  out  1  sticky: out-of-range coordinate seen in current/last window

## Operation
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
- IDLE: set=1 -> ACTIVE. That coordinate is accepted, and stats and oob_err are cleared on the same edge (count=0, sum=0, min=all-ones, max=0).
- ACTIVE: every cycle with set=1 accepts one coordinate. set=0 -> DRAIN.
- DRAIN: no new coordinates. When the read pipeline is empty (no valid bit in flight and no pix_valid pending) -> DONE.
- DONE: win_done=1 for exactly one cycle -> IDLE.
- set=1 in DRAIN or DONE: the coordinate is dropped and oob_err is set. A new window starts only from IDLE.
- Address generation: ram_addr = y*COLS + x, computed 13-bit unsigned from registered inputs. Use shift-and-add for COLS=80 (y<<6 + y<<4 + x).
- Out-of-range coordinate (x>=COLS or y>=ROWS):
  - ram_rd_en stays 0 for that slot and oob_err is set.
  - The slot still travels the pipeline, so ordering is preserved, but it yields no pix_valid and no stats update.
- Stats update on every pix_valid edge, using pix_data:
  - count += 1
  - sum += data (no overflow possible: 5120*(2^16-1) < 2^29)
  - min/max compare unsigned
- win_count, win_sum, win_min and win_max hold their values from DONE until the first accepted coordinate of the next window.

## Timing
- Reset values: ram_rd_en=0, ram_addr=0, pix_valid=0, pix_x=0, pix_y=0, pix_data=0, win_done=0, win_count=0, win_sum=0, win_min=0, win_max=0, oob_err=0. FSM resets to IDLE.
- Coordinate sampled at edge N:
  - ram_rd_en/ram_addr registered at edge N.
  - ram_rdata sampled at edge N+RD_LAT.
  - pix_* and stats registered on the same edge, so pix_valid is high in the cycle after edge N+RD_LAT.
  - Latency from sampling edge to pix_valid high is RD_LAT+1 cycles.
- Back-to-back coordinates produce back-to-back pix_valid. Throughput is one pixel per cycle with no stall.
- win_done rises in the cycle after the last pix_valid cycle, or later if trailing slots are out-of-range. Stats are final while win_done=1.
- rst_n asserted mid-window: the in-flight pipeline is discarded, no win_done is issued, and all outputs take their reset values immediately.

## Structure
- Shared package htpa_pkg holds COLS, ROWS, the X_W=7/Y_W=6/ADDR_W=13 constants, and the FSM state enum. The window scanner and this block both import it.
- One sub-module, htpa_win_stats: holds the count/sum/min/max accumulators, with clear and update strobes. The top level keeps the FSM, address stage, and the valid/x/y delay line of depth RD_LAT.

## Test plan
- Single pixel: set=1 for 1 cycle at (5,3), RAM returns 0x1234 -> ram_addr=245. pix_valid after RD_LAT+1 cycles with pix_x=5, pix_y=3. win_done 1 cycle later with count=1, sum=min=max=0x1234.
- Full row: x=0..79, y=0 contiguous, RAM data = address -> 80 consecutive pix_valid, count=80, sum=3160, min=0, max=79.
- Out-of-range: window includes x=85, y=2 -> no ram_rd_en for that slot, oob_err=1, count excludes it, other pixels are unaffected and stay in order.
- Full frame 80x64, all data 0xFFFF -> count=5120, sum=5120*65535 with no wrap, min=max=0xFFFF.
- Reset mid-window after 10 coordinates -> all outputs 0 and no win_done. A following window starts with cleared stats.
- set=1 re-asserted during DRAIN -> coordinate dropped, oob_err=1, and win_done/stats reflect the first window only. RD_LAT=1 and RD_LAT=4 builds pass all of the above.
